gate_load_sequencer: RTL and testbench

//  Controller in front of one gate datapath and its two weightRAM instances (X: HIDDEN_SZxINPUT_SZ, Y: HIDDEN_SZxHIDDEN_SZ).
//  Per sample it accepts HIDDEN_SZ column beats, writes weight columns and bias slices, and holds the gate in reset while loading.
//  It then pulses beginCalc, waits for dataReady_gate and reports completion.

---
 rtl/gate_load_sequencer_pkg.sv | 21 ++
 rtl/gate_load_sequencer_if.sv | 51 +++++
 rtl/gate_load_sequencer_watchdog.sv | 31 +++
 rtl/gate_load_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_gate_load_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_load_sequencer_pkg.sv
// Shared types and helpers for the gate load sequencer.
// Configuration macro (see gate_load_sequencer.sv): GATE_SEQ_TIMEOUT_EN.
package gate_load_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int SAMPLE_CNT_W = 16;

  // Width of one signed fixed-point word: sign + integer + fraction bits.
  function automatic int word_bits(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

endpackage

// File: rtl/gate_load_sequencer_if.sv
// Column-load / gate-control bus of the gate load sequencer.
// slave: the sequencer itself; master: the column source and gate side.
interface gate_load_sequencer_if #(
  parameter int INPUT_SZ  = 4,
  parameter int HIDDEN_SZ = 32,
  parameter int QN        = 7,
  parameter int QM        = 10
);
  import gate_load_sequencer_pkg::*;

  localparam int BITWIDTH        = word_bits(QN, QM);
  localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ;
  localparam int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ);
  localparam int ADDR_BITWIDTH_X = $clog2(INPUT_SZ);

  logic                        loadStart;
  logic                        colValid;
  logic                        colReady;
  logic [LAYER_BITWIDTH-1:0]   colWeightX;
  logic [LAYER_BITWIDTH-1:0]   colWeightY;
  logic [BITWIDTH-1:0]         colBias;
  logic [ADDR_BITWIDTH_X-1:0]  colAddressWrite_X;
  logic [ADDR_BITWIDTH-1:0]    colAddressWrite_Y;
  logic                        writeEn_X;
  logic                        writeEn_Y;
  logic [LAYER_BITWIDTH-1:0]   weightMemInput_X;
  logic [LAYER_BITWIDTH-1:0]   weightMemInput_Y;
  logic [LAYER_BITWIDTH-1:0]   biasVec;
  logic                        gateReset;
  logic                        beginCalc;
  logic                        dataReady_gate;
  logic                        busy;
  logic                        sampleDone;
  logic [SAMPLE_CNT_W-1:0]     sampleCount;
  logic                        timeoutErr;

  modport slave (
    input  loadStart, colValid, colWeightX, colWeightY, colBias, dataReady_gate,
    output colReady, colAddressWrite_X, colAddressWrite_Y, writeEn_X, writeEn_Y,
           weightMemInput_X, weightMemInput_Y, biasVec, gateReset, beginCalc,
           busy, sampleDone, sampleCount, timeoutErr
  );

  modport master (
    output loadStart, colValid, colWeightX, colWeightY, colBias, dataReady_gate,
    input  colReady, colAddressWrite_X, colAddressWrite_Y, writeEn_X, writeEn_Y,
           weightMemInput_X, weightMemInput_Y, biasVec, gateReset, beginCalc,
           busy, sampleDone, sampleCount, timeoutErr
  );

endinterface

// File: rtl/gate_load_sequencer_watchdog.sv
// gate_seq_watchdog: WAIT-state cycle counter with limit compare.
// Only present when GATE_SEQ_TIMEOUT_EN is defined.
`ifdef GATE_SEQ_TIMEOUT_EN
module gate_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count while running; any cycle outside WAIT clears, so every entry starts at 0.
  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/gate_load_sequencer.sv
// gate_load_sequencer: loads HIDDEN_SZ weight/bias columns into the X/Y
// weight RAMs and the bias vector, holds the gate in reset while loading,
// then kicks the gate and waits for its result.
// Optional macro GATE_SEQ_TIMEOUT_EN adds a WAIT watchdog (timeoutErr).
module gate_load_sequencer
  import gate_load_sequencer_pkg::*;
#(
  parameter int INPUT_SZ       = 4,
  parameter int HIDDEN_SZ      = 32,
  parameter int QN             = 7,
  parameter int QM             = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  gate_load_sequencer_if.slave  bus
);
  localparam int BITWIDTH        = word_bits(QN, QM);
  localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ;
  localparam int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ);
  localparam int ADDR_BITWIDTH_X = $clog2(INPUT_SZ);
  localparam int KW              = ADDR_BITWIDTH + 1;

  if (HIDDEN_SZ < INPUT_SZ) begin : g_bad_size
    $error("HIDDEN_SZ must be >= INPUT_SZ");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t                      state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]    k_q, k_d;
  logic [ADDR_BITWIDTH_X-1:0]  addr_x_q, addr_x_d;
  logic [ADDR_BITWIDTH-1:0]    addr_y_q, addr_y_d;
  logic                        we_x_q, we_x_d;
  logic                        we_y_q, we_y_d;
  logic [LAYER_BITWIDTH-1:0]   wmem_x_q, wmem_x_d;
  logic [LAYER_BITWIDTH-1:0]   wmem_y_q, wmem_y_d;
  logic [LAYER_BITWIDTH-1:0]   bias_vec_q, bias_vec_d;
  logic                        gate_rst_q, gate_rst_d;
  logic                        begin_calc_q, begin_calc_d;
  logic                        sample_done_q, sample_done_d;
  logic [SAMPLE_CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic                        drdy_q, drdy_d;
  logic                        timeout_err_q, timeout_err_d;
  logic                        dr_rise;
  logic                        wd_expired;

`ifdef GATE_SEQ_TIMEOUT_EN
  gate_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Only a low->high transition counts; the edge register is 0 on KICK entry
  // and samples the level from KICK on, so a level already high is ignored.
  assign dr_rise = bus.dataReady_gate && !drdy_q;

  // Next-state, column write path, bias assembly and status.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    addr_x_d      = addr_x_q;
    addr_y_d      = addr_y_q;
    we_x_d        = 1'b0;
    we_y_d        = 1'b0;
    wmem_x_d      = wmem_x_q;
    wmem_y_d      = wmem_y_q;
    bias_vec_d    = bias_vec_q;
    gate_rst_d    = gate_rst_q;
    begin_calc_d  = 1'b0;
    sample_done_d = 1'b0;
    sample_cnt_d  = sample_cnt_q;
    drdy_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.loadStart) begin
          state_d    = ST_LOAD;
          gate_rst_d = 1'b1;
          k_d        = '0;
        end
      end
      ST_LOAD: begin
        if (bus.colValid) begin
          wmem_x_d = bus.colWeightX;
          wmem_y_d = bus.colWeightY;
          addr_y_d = k_q;
          addr_x_d = k_q[ADDR_BITWIDTH_X-1:0];
          we_y_d   = 1'b1;
          // Wx has only INPUT_SZ columns; later beats carry Y/bias only.
          we_x_d   = ({1'b0, k_q} < KW'(INPUT_SZ));
          bias_vec_d[k_q*BITWIDTH +: BITWIDTH] = bus.colBias;
          k_d      = k_q + ADDR_BITWIDTH'(1);
          if (k_q == ADDR_BITWIDTH'(HIDDEN_SZ - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d      = ST_KICK;
        gate_rst_d   = 1'b0;
        begin_calc_d = 1'b1;
      end
      ST_KICK: begin
        state_d = ST_WAIT;
        drdy_d  = bus.dataReady_gate;
      end
      ST_WAIT: begin
        drdy_d = bus.dataReady_gate;
        if (dr_rise || wd_expired) begin
          state_d       = ST_DONE;
          sample_done_d = 1'b1;
          sample_cnt_d  = sample_cnt_q + SAMPLE_CNT_W'(1);
          if (!dr_rise) timeout_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Gate stays out of reset so its result remains readable.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      addr_x_q      <= '0;
      addr_y_q      <= '0;
      we_x_q        <= 1'b0;
      we_y_q        <= 1'b0;
      wmem_x_q      <= '0;
      wmem_y_q      <= '0;
      bias_vec_q    <= '0;
      gate_rst_q    <= 1'b1;
      begin_calc_q  <= 1'b0;
      sample_done_q <= 1'b0;
      sample_cnt_q  <= '0;
      drdy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      addr_x_q      <= addr_x_d;
      addr_y_q      <= addr_y_d;
      we_x_q        <= we_x_d;
      we_y_q        <= we_y_d;
      wmem_x_q      <= wmem_x_d;
      wmem_y_q      <= wmem_y_d;
      bias_vec_q    <= bias_vec_d;
      gate_rst_q    <= gate_rst_d;
      begin_calc_q  <= begin_calc_d;
      sample_done_q <= sample_done_d;
      sample_cnt_q  <= sample_cnt_d;
      drdy_q        <= drdy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.colReady          = (state_q == ST_LOAD);
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.colAddressWrite_X = addr_x_q;
  assign bus.colAddressWrite_Y = addr_y_q;
  assign bus.writeEn_X         = we_x_q;
  assign bus.writeEn_Y         = we_y_q;
  assign bus.weightMemInput_X  = wmem_x_q;
  assign bus.weightMemInput_Y  = wmem_y_q;
  assign bus.biasVec           = bias_vec_q;
  assign bus.gateReset         = gate_rst_q;
  assign bus.beginCalc         = begin_calc_q;
  assign bus.sampleDone        = sample_done_q;
  assign bus.sampleCount       = sample_cnt_q;
  assign bus.timeoutErr        = timeout_err_q;

endmodule

// File: tb/tb_gate_load_sequencer.sv
// Directed, table-driven bench for gate_load_sequencer.
module tb_gate_load_sequencer;
  localparam int INPUT_SZ  = 4;
  localparam int HIDDEN_SZ = 32;
  localparam int QN        = 7;
  localparam int QM        = 10;
  localparam int TO        = 64;
  localparam int BW        = QN + QM + 1;
  localparam int LBW       = BW * HIDDEN_SZ;

  typedef struct {
    bit valid;
    int beat;
    bit we_x;
    bit we_y;
  } row_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] exp_count;

  gate_load_sequencer_if #(.INPUT_SZ(INPUT_SZ), .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM)) bus ();

  gate_load_sequencer #(
    .INPUT_SZ(INPUT_SZ), .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LBW-1:0] col_w(input int k, input int base);
    logic [LBW-1:0] r;
    r = '0;
    for (int l = 0; l < HIDDEN_SZ; l++) r[l*BW +: BW] = BW'(base + k * 64 + l);
    return r;
  endfunction

  // Load one sample; nrows limits how many table rows are applied.
  task automatic run_load(input bit stall, input int nrows, input int seed);
    row_t rows [40];
    int total, kk, writes, n;
    total = stall ? HIDDEN_SZ + 5 : HIDDEN_SZ;
    kk = 0;
    for (int i = 0; i < total; i++) begin
      rows[i].valid = !(stall && i >= 10 && i < 15);
      rows[i].beat  = kk;
      rows[i].we_y  = rows[i].valid;
      rows[i].we_x  = rows[i].valid && (kk < INPUT_SZ);
      if (rows[i].valid) kk++;
    end
    n = (nrows > total) ? total : nrows;
    bus.loadStart = 1'b1;
    step();
    bus.loadStart = 1'b0;
    chk("load_busy", bus.busy, 1);
    chk("load_col_ready", bus.colReady, 1);
    chk("load_gate_reset", bus.gateReset, 1);
    writes = 0;
    for (int i = 0; i < n; i++) begin
      bus.colValid   = rows[i].valid;
      bus.colWeightX = col_w(rows[i].beat, 1);
      bus.colWeightY = col_w(rows[i].beat, 131072);
      bus.colBias    = BW'(rows[i].beat + seed);
      step();
      chk("we_y", bus.writeEn_Y, rows[i].we_y);
      chk("we_x", bus.writeEn_X, rows[i].we_x);
      chk("col_ready", bus.colReady, (i != total - 1));
      chk("gate_reset_in_load", bus.gateReset, 1);
      if (rows[i].valid) begin
        chk("addr_y", bus.colAddressWrite_Y, rows[i].beat);
        chk("addr_x", bus.colAddressWrite_X, rows[i].beat % INPUT_SZ);
        chk_w("wmem_x", bus.weightMemInput_X, col_w(rows[i].beat, 1));
        chk_w("wmem_y", bus.weightMemInput_Y, col_w(rows[i].beat, 131072));
      end
      writes += int'(bus.writeEn_Y);
    end
    bus.colValid = 1'b0;
    if (n == total) begin
      chk("flush_begin_calc", bus.beginCalc, 0);
      step();
      chk("kick_begin_calc", bus.beginCalc, 1);
      chk("kick_gate_reset", bus.gateReset, 0);
      chk("kick_we_y", bus.writeEn_Y, 0);
      chk("write_total", writes, HIDDEN_SZ);
      for (int k = 0; k < HIDDEN_SZ; k++)
        chk("bias_slice", bus.biasVec[k*BW +: BW], BW'(k + seed));
    end
  endtask

  task automatic finish_sample();
    bus.dataReady_gate = 1'b1;
    step();
    exp_count++;
    chk("done_pulse", bus.sampleDone, 1);
    chk("sample_count", bus.sampleCount, exp_count);
    bus.dataReady_gate = 1'b0;
    step();
    chk("done_one_cycle", bus.sampleDone, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_gate_reset", bus.gateReset, 0);
  endtask

  task automatic enter_wait();
    step();
    chk("wait_busy", bus.busy, 1);
    chk("wait_begin_calc", bus.beginCalc, 0);
    chk("wait_no_done", bus.sampleDone, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c;
    checks = 0; errors = 0; exp_count = '0;
    reset = 1'b1;
    bus.loadStart = 1'b0; bus.colValid = 1'b0; bus.dataReady_gate = 1'b0;
    bus.colWeightX = '0; bus.colWeightY = '0; bus.colBias = '0;
    repeat (3) step();
    chk("rst_gate_reset", bus.gateReset, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_col_ready", bus.colReady, 0);
    chk("rst_we_y", bus.writeEn_Y, 0);
    chk("rst_begin_calc", bus.beginCalc, 0);
    chk("rst_sample_done", bus.sampleDone, 0);
    chk("rst_sample_count", bus.sampleCount, 0);
    chk("rst_timeout", bus.timeoutErr, 0);
    chk_w("rst_bias", bus.biasVec, '0);
    reset = 1'b0;
    step();

    // colValid outside LOAD is ignored
    bus.colValid = 1'b1;
    step();
    chk("idle_colvalid_we", bus.writeEn_Y, 0);
    chk("idle_col_ready", bus.colReady, 0);
    bus.colValid = 1'b0;

    // Back-to-back load, bias = k
    run_load(1'b0, 99, 0);
    enter_wait();
    finish_sample();

    // Stall at k=10 for 5 cycles
    run_load(1'b1, 99, 300);
    enter_wait();
    finish_sample();

    // dataReady already high at WAIT entry; only the later rise counts
    bus.dataReady_gate = 1'b1;
    run_load(1'b0, 99, 600);
    repeat (3) enter_wait();
    bus.loadStart = 1'b1;
    step();
    bus.loadStart = 1'b0;
    chk("loadstart_in_wait_ignored", bus.colReady, 0);
    bus.dataReady_gate = 1'b0;
    enter_wait();
    enter_wait();
    finish_sample();
    chk("three_samples", bus.sampleCount, 3);
    step();
    chk("gate_reset_held_idle", bus.gateReset, 0);

    // Async reset at k=17, then a fresh complete load
    run_load(1'b0, 17, 900);
    #2 reset = 1'b1;
    #1;
    chk("midrst_gate_reset", bus.gateReset, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_we_y", bus.writeEn_Y, 0);
    chk("midrst_sample_count", bus.sampleCount, 0);
    chk_w("midrst_wmem_y", bus.weightMemInput_Y, '0);
    chk_w("midrst_bias", bus.biasVec, '0);
    exp_count = '0;
    step();
    reset = 1'b0;
    step();
    run_load(1'b0, 99, 1200);
    enter_wait();
    finish_sample();

    // dataReady held low in WAIT
    run_load(1'b0, 99, 1500);
`ifdef GATE_SEQ_TIMEOUT_EN
    c = 0;
    do begin
      step();
      c++;
    end while (!bus.sampleDone && c < 200);
    chk("timeout_latency", c - 1, TO);
    exp_count++;
    chk("timeout_sample_count", bus.sampleCount, exp_count);
    chk("timeout_err_set", bus.timeoutErr, 1);
    step();
    chk("timeout_back_idle", bus.busy, 0);
    chk("timeout_err_sticky", bus.timeoutErr, 1);
`else
    c = 0;
    repeat (100) begin
      step();
      c++;
    end
    chk("no_timeout_still_wait", bus.busy, 1);
    chk("no_timeout_err", bus.timeoutErr, 0);
    finish_sample();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
